pending_write_queue: RTL and testbench

Show-ahead FIFO between the pixel-write producer (host command decoder) and the memory manager. It accepts coordinate/colour writes, validates them against the 320×240 frame, and packs them into 25-bit `{address, data}` entries. It presents the head entry to the memory manager's pending-write read port, which drains one entry per write slot. Optional write coalescing merges back-to-back writes to the same pixel.

---
 rtl/video_pkg.sv | 27 ++
 rtl/pending_write_ram.sv | 39 +++
 rtl/pending_write_queue.sv | 144 ++++++++++++++
 tb/tb_pending_write_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: definitions shared by the video pipeline blocks.
//   SCREEN_WIDTH / SCREEN_HEIGHT : visible frame size in pixels
//   pending_write_t              : packed {y, x, color} pixel-write entry (25 bits)
//   mem_phase_t / MEM_PHASES     : memory manager clock-phase encoding
package video_pkg;

  localparam int unsigned SCREEN_WIDTH  = 320;
  localparam int unsigned SCREEN_HEIGHT = 240;

  // Bits 24:8 form the SRAM address; bits 7:0 are the pixel value.
  typedef struct packed {
    logic [7:0] y;
    logic [8:0] x;
    logic [7:0] color;
  } pending_write_t;

  // Memory manager slot phases, one per system clock within a slot.
  typedef enum logic [1:0] {
    PhaseRefresh,
    PhaseRead,
    PhaseWrite,
    PhaseIdle
  } mem_phase_t;

  localparam int unsigned MEM_PHASES = 4;

endpackage

// File: rtl/pending_write_ram.sv
// pending_write_ram: DEPTH x 25-bit register array for the pending-write queue.
// Synchronous write, two asynchronous read ports.
//   clock        : write clock
//   write_en     : store write_data at write_addr on the rising edge
//   write_addr   : write index
//   write_data   : entry to store
//   read_addr_a  : head index (show-ahead read port)
//   read_data_a  : entry at read_addr_a
//   read_addr_b  : tail-1 index (used for write coalescing)
//   read_data_b  : entry at read_addr_b
module pending_write_ram
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           write_en,
  input  logic [AW-1:0]  write_addr,
  input  pending_write_t write_data,
  input  logic [AW-1:0]  read_addr_a,
  output pending_write_t read_data_a,
  input  logic [AW-1:0]  read_addr_b,
  output pending_write_t read_data_b
);

  // No reset: contents are never visible until written.
  pending_write_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data_a = mem[read_addr_a];
  assign read_data_b = mem[read_addr_b];

endmodule

// File: rtl/pending_write_queue.sv
// pending_write_queue: show-ahead FIFO from the pixel-write producer to the memory manager.
// Validates coordinates against the frame, packs {y, x, color} entries and presents the head.
// Optional feature macro: PENDING_WRITE_QUEUE_COALESCE_EN merges a push into the most recently
// stored entry when the address matches.
//   clock / reset                 : system clock, asynchronous active-low reset
//   writeXCoord/YCoord/Color      : pixel write payload
//   writeRequest / writeAccept    : push qualifier / push will be taken this cycle
//   pendingWriteQueueReadBus      : head entry, 0 while empty
//   pendingWriteQueueReadEmpty    : no entries stored
//   pendingWriteQueueReadRequest  : pop qualifier (ignored while empty)
//   count                         : stored entries, 0..DEPTH
//   overflow / rangeError         : sticky error flags
//   clearErrors                   : synchronous clear of the sticky flags (set wins)
module pending_write_queue
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [8:0]               writeXCoord,
  input  logic [7:0]               writeYCoord,
  input  logic [7:0]               writeColor,
  input  logic                     writeRequest,
  output logic                     writeAccept,
  output logic [24:0]              pendingWriteQueueReadBus,
  output logic                     pendingWriteQueueReadEmpty,
  input  logic                     pendingWriteQueueReadRequest,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     rangeError,
  input  logic                     clearErrors
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          range_error_q, range_error_d;

  logic           in_range;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           addr_match;
  logic           coalesce_hit;
  logic [AW-1:0]  tail_ptr;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;
  pending_write_t new_entry;
  pending_write_t head_entry;
  pending_write_t tail_entry;

  assign in_range = (writeXCoord < 9'(SCREEN_WIDTH)) && (writeYCoord < 8'(SCREEN_HEIGHT));
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign tail_ptr = wr_ptr_q - AW'(1);
  assign pop      = pendingWriteQueueReadRequest && !empty;

  assign new_entry.y     = writeYCoord;
  assign new_entry.x     = writeXCoord;
  assign new_entry.color = writeColor;

`ifdef PENDING_WRITE_QUEUE_COALESCE_EN
  // Stored entries are always in range, so a match implies an in-range push.
  assign addr_match   = !empty && (tail_entry.y == writeYCoord) && (tail_entry.x == writeXCoord);
  // With a single entry being popped this edge, the target is leaving; allocate instead.
  assign coalesce_hit = writeRequest && addr_match && !((count_q == CW'(1)) && pop);
`else
  logic unused_tail_entry;
  assign unused_tail_entry = ^tail_entry;
  assign addr_match        = 1'b0;
  assign coalesce_hit      = 1'b0;
`endif

  // addr_match excludes the pop term: when full, count > 1, so the pop cannot cancel a hit.
  assign writeAccept = !full || addr_match;
  assign push        = writeRequest && writeAccept && in_range && !coalesce_hit;

  assign ram_we    = push || coalesce_hit;
  assign ram_waddr = coalesce_hit ? tail_ptr : wr_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Set wins over clear.
  assign overflow_d    = (overflow_q && !clearErrors) || (writeRequest && !writeAccept);
  assign range_error_d = (range_error_q && !clearErrors) || (writeRequest && !in_range);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      range_error_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      range_error_q <= range_error_d;
    end
  end

  pending_write_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clock      (clock),
    .write_en   (ram_we),
    .write_addr (ram_waddr),
    .write_data (new_entry),
    .read_addr_a(rd_ptr_q),
    .read_data_a(head_entry),
    .read_addr_b(tail_ptr),
    .read_data_b(tail_entry)
  );

  assign pendingWriteQueueReadBus   = empty ? '0 : head_entry;
  assign pendingWriteQueueReadEmpty = empty;
  assign count                      = count_q;
  assign overflow                   = overflow_q;
  assign rangeError                 = range_error_q;

endmodule

// File: tb/tb_pending_write_queue.sv
// tb_pending_write_queue: directed self-checking bench for pending_write_queue (DEPTH = 16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pending_write_queue;

  localparam int unsigned DEPTH = 16;

  logic        clock;
  logic        reset;
  logic [8:0]  writeXCoord;
  logic [7:0]  writeYCoord;
  logic [7:0]  writeColor;
  logic        writeRequest;
  logic        writeAccept;
  logic [24:0] pendingWriteQueueReadBus;
  logic        pendingWriteQueueReadEmpty;
  logic        pendingWriteQueueReadRequest;
  logic [4:0]  count;
  logic        overflow;
  logic        rangeError;
  logic        clearErrors;

  int n_checks = 0;
  int n_errors = 0;

  logic [24:0] model_q[$];

  pending_write_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .clock                       (clock),
    .reset                       (reset),
    .writeXCoord                 (writeXCoord),
    .writeYCoord                 (writeYCoord),
    .writeColor                  (writeColor),
    .writeRequest                (writeRequest),
    .writeAccept                 (writeAccept),
    .pendingWriteQueueReadBus    (pendingWriteQueueReadBus),
    .pendingWriteQueueReadEmpty  (pendingWriteQueueReadEmpty),
    .pendingWriteQueueReadRequest(pendingWriteQueueReadRequest),
    .count                       (count),
    .overflow                    (overflow),
    .rangeError                  (rangeError),
    .clearErrors                 (clearErrors)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] ent(input int x, input int y, input int c);
    return {y[7:0], x[8:0], c[7:0]};
  endfunction

  task automatic drive(input int x, input int y, input int c, input logic req);
    writeXCoord  = x[8:0];
    writeYCoord  = y[7:0];
    writeColor   = c[7:0];
    writeRequest = req;
  endtask

  // One rising edge; returns on the following falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic clear_flags();
    clearErrors = 1'b1;
    step();
    clearErrors = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 1'b0);
    pendingWriteQueueReadRequest = 1'b0;
    clearErrors = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", pendingWriteQueueReadEmpty, 1);
    check("rst_bus", pendingWriteQueueReadBus, 0);
    check("rst_overflow", overflow, 0);
    check("rst_range", rangeError, 0);
    check("rst_accept", writeAccept, 1);

    // Single write then pop
    drive(5, 7, 8'hAA, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("single_empty", pendingWriteQueueReadEmpty, 0);
    check("single_bus", pendingWriteQueueReadBus, 25'h0E05AA);
    check("single_count", count, 1);
    pendingWriteQueueReadRequest = 1'b1;
    step();
    pendingWriteQueueReadRequest = 1'b0;
    check("single_pop_empty", pendingWriteQueueReadEmpty, 1);
    check("single_pop_bus", pendingWriteQueueReadBus, 0);
    // Pop while empty changes nothing
    pendingWriteQueueReadRequest = 1'b1;
    step();
    pendingWriteQueueReadRequest = 1'b0;
    check("empty_pop_count", count, 0);

    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      drive(i * 3, i, 8'h10 + i, 1'b1);
      step();
    end
    drive(0, 0, 0, 1'b0);
    check("fill_count", count, 16);
    check("fill_accept", writeAccept, 0);
    check("fill_overflow_clear", overflow, 0);
    // Pop request while full does not free a slot for a same-cycle push
    drive(100, 100, 8'hEE, 1'b1);
    pendingWriteQueueReadRequest = 1'b1;
    check("full_accept_with_pop", writeAccept, 0);
    step();
    drive(0, 0, 0, 1'b0);
    pendingWriteQueueReadRequest = 1'b0;
    check("full_overflow", overflow, 1);
    check("full_pop_count", count, 15);
    // 17th request against a full queue (refill the popped slot first)
    drive(3 * 16, 16, 8'h20, 1'b1);
    step();
    drive(200, 200, 8'hEF, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("overflow_count", count, 16);
    pendingWriteQueueReadRequest = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("drain_%0d", i), pendingWriteQueueReadBus, ent(i * 3, i, 8'h10 + i));
      step();
    end
    pendingWriteQueueReadRequest = 1'b0;
    check("drain_empty", pendingWriteQueueReadEmpty, 1);
    clear_flags();
    check("overflow_cleared", overflow, 0);

    // Out-of-range push
    drive(320, 0, 8'h33, 1'b1);
    check("range_accept", writeAccept, 1);
    step();
    drive(0, 0, 0, 1'b0);
    check("range_flag", rangeError, 1);
    check("range_count", count, 0);
    check("range_accept_after", writeAccept, 1);
    drive(0, 240, 8'h33, 1'b1);
    clearErrors = 1'b1;
    step();
    drive(0, 0, 0, 1'b0);
    clearErrors = 1'b0;
    check("range_set_wins", rangeError, 1);
    clear_flags();
    check("range_cleared", rangeError, 0);
    check("range_y_count", count, 0);

    // Simultaneous push/pop at count 3
    for (int i = 0; i < 3; i++) begin
      drive(50 + i, 60, 8'hA0 + i, 1'b1);
      step();
    end
    drive(53, 60, 8'hA3, 1'b1);
    pendingWriteQueueReadRequest = 1'b1;
    step();
    drive(0, 0, 0, 1'b0);
    pendingWriteQueueReadRequest = 1'b0;
    check("pp3_count", count, 3);
    check("pp3_head", pendingWriteQueueReadBus, ent(51, 60, 8'hA1));
    pendingWriteQueueReadRequest = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("pp3_drain_%0d", i), pendingWriteQueueReadBus, ent(50 + i, 60, 8'hA0 + i));
      step();
    end
    // Simultaneous at count 0: only the push happens
    drive(319, 239, 8'h77, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    pendingWriteQueueReadRequest = 1'b0;
    check("pp0_count", count, 1);
    check("pp0_overflow", overflow, 0);
    check("pp0_bus", pendingWriteQueueReadBus, ent(319, 239, 8'h77));
    pendingWriteQueueReadRequest = 1'b1;
    step();
    pendingWriteQueueReadRequest = 1'b0;

    // Wrap: 40 push/pop pairs against a queue model
    model_q.delete();
    drive(0, 0, 8'h5A, 1'b1);
    step();
    model_q.push_back(ent(0, 0, 8'h5A));
    for (int i = 1; i <= 40; i++) begin
      drive((i * 7) % 320, i, i ^ 8'h5A, 1'b1);
      pendingWriteQueueReadRequest = 1'b1;
      check($sformatf("wrap_%0d", i), pendingWriteQueueReadBus, model_q[0]);
      step();
      void'(model_q.pop_front());
      model_q.push_back(ent((i * 7) % 320, i, i ^ 8'h5A));
    end
    drive(0, 0, 0, 1'b0);
    pendingWriteQueueReadRequest = 1'b0;
    check("wrap_count", count, 1);
    check("wrap_tail", pendingWriteQueueReadBus, model_q[0]);
    // Asynchronous reset mid-stream
    drive(11, 12, 8'h13, 1'b1);
    step();
    #2 reset = 1'b0;
    #1;
    check("async_rst_empty", pendingWriteQueueReadEmpty, 1);
    check("async_rst_count", count, 0);
    check("async_rst_bus", pendingWriteQueueReadBus, 0);
    drive(0, 0, 0, 1'b0);
    step();
    reset = 1'b1;
    step();

`ifdef PENDING_WRITE_QUEUE_COALESCE_EN
    drive(10, 20, 8'h11, 1'b1);
    step();
    drive(10, 20, 8'h22, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("coal_count", count, 1);
    check("coal_bus", pendingWriteQueueReadBus, ent(10, 20, 8'h22));
    for (int i = 1; i < DEPTH; i++) begin
      drive(i, 100, i, 1'b1);
      step();
    end
    drive(15, 100, 8'hCC, 1'b1);
    check("coal_full_accept", writeAccept, 1);
    step();
    drive(0, 0, 0, 1'b0);
    check("coal_full_count", count, 16);
    check("coal_full_overflow", overflow, 0);
    pendingWriteQueueReadRequest = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) step();
    pendingWriteQueueReadRequest = 1'b0;
    check("coal_full_entry", pendingWriteQueueReadBus, ent(15, 100, 8'hCC));
`else
    drive(10, 20, 8'h11, 1'b1);
    step();
    drive(10, 20, 8'h22, 1'b1);
    step();
    drive(0, 0, 0, 1'b0);
    check("nocoal_count", count, 2);
    check("nocoal_head", pendingWriteQueueReadBus, ent(10, 20, 8'h11));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
